// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: load size encodings, the hardwired zero
// register and the default depth of the writeback queue.
package mips_pkg;

    localparam logic [1:0] LD_BYTE  = 2'b00;
    localparam logic [1:0] LD_HALF  = 2'b01;
    localparam logic [1:0] LD_WORD  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int WB_DEPTH = 4;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a raw load word and sign- or
// zero-extends it to 32 bits; any word size encoding passes the word through.
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] ld_data,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [1:0]  ld_byte_off,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = ld_data[{ld_byte_off, 3'b000} +: 8];
        half_val = ld_data[{ld_byte_off[1], 4'b0000} +: 16];
        case (ld_size)
            LD_BYTE: ext_data = {{24{ld_signed & byte_val[7]}}, byte_val};
            LD_HALF: ext_data = {{16{ld_signed & half_val[15]}}, half_val};
            default: ext_data = ld_data;
        endcase
    end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback queue: merges ALU and load results into one write
// port, draining one entry per cycle and forwarding pending values to readers.
module writeback_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_addr,
    input  logic [31:0]              alu_data,

    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_addr,
    input  logic [31:0]              ld_data,
    input  logic [1:0]               ld_size,
    input  logic                     ld_signed,
    input  logic [1:0]               ld_byte_off,

    output logic                     w_en,
    output logic [4:0]               w_address_d_5,
    output logic [31:0]              w_data_dval_32,

    input  logic [4:0]               fwd_address_s1_5,
    input  logic [4:0]               fwd_address_s2_5,
    output logic                     fwd_hit_s1,
    output logic                     fwd_hit_s2,
    output logic [31:0]              fwd_data_s1_32,
    output logic [31:0]              fwd_data_s2_32,

    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] alu_slot;
    logic [CW-1:0] free_slots;
    logic [31:0]   ld_ext;
    logic          ld_accept;
    logic          alu_accept;
    logic          store_ld;
    logic          store_alu;
    logic          deq;

    load_extend u_load_extend (
        .ld_data     (ld_data),
        .ld_size     (ld_size),
        .ld_signed   (ld_signed),
        .ld_byte_off (ld_byte_off),
        .ext_data    (ld_ext)
    );

    // Readiness uses registered occupancy only, so a same-cycle dequeue never
    // frees space; a lone load gets priority when just one slot remains.
    assign free_slots = DEPTH_C - occupancy;
    assign ld_ready   = (free_slots >= ONE_C);
    assign alu_ready  = (free_slots >= TWO_C) | ((free_slots >= ONE_C) & ~ld_valid);

    assign ld_accept  = ld_valid & ld_ready;
    assign alu_accept = alu_valid & alu_ready;
    assign store_ld   = ld_accept & (ld_addr != REG_ZERO);
    assign store_alu  = alu_accept & (alu_addr != REG_ZERO);
    assign deq        = (occupancy != '0);
    assign alu_slot   = wr_ptr + AW'(store_ld);

    always_ff @(posedge clock) begin
        if (store_ld) begin
            mem_addr[wr_ptr] <= ld_addr;
            mem_data[wr_ptr] <= ld_ext;
        end
        if (store_alu) begin
            mem_addr[alu_slot] <= alu_addr;
            mem_data[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(store_ld) + AW'(store_alu);
            rd_ptr    <= rd_ptr + AW'(deq);
            occupancy <= occupancy + CW'(store_ld) + CW'(store_alu) - CW'(deq);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_en           <= 1'b0;
            w_address_d_5  <= '0;
            w_data_dval_32 <= '0;
        end else if (deq) begin
            w_en           <= 1'b1;
            w_address_d_5  <= mem_addr[rd_ptr];
            w_data_dval_32 <= mem_data[rd_ptr];
        end else begin
            w_en           <= 1'b0;
        end
    end

    logic [4:0]  fwd_addr [2];
    logic        fwd_hit  [2];
    logic [31:0] fwd_data [2];

    assign fwd_addr[0] = fwd_address_s1_5;
    assign fwd_addr[1] = fwd_address_s2_5;

    // Scan oldest to youngest (output register, then head..tail) so the last
    // match, i.e. the youngest pending write, is the value forwarded.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            fwd_hit[s]  = 1'b0;
            fwd_data[s] = '0;
            if (fwd_addr[s] != REG_ZERO) begin
                if (w_en && (w_address_d_5 == fwd_addr[s])) begin
                    fwd_hit[s]  = 1'b1;
                    fwd_data[s] = w_data_dval_32;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if ((CW'(k) < occupancy) && (mem_addr[rd_ptr + AW'(k)] == fwd_addr[s])) begin
                        fwd_hit[s]  = 1'b1;
                        fwd_data[s] = mem_data[rd_ptr + AW'(k)];
                    end
                end
            end
        end
    end

    assign fwd_hit_s1     = fwd_hit[0];
    assign fwd_hit_s2     = fwd_hit[1];
    assign fwd_data_s1_32 = fwd_data[0];
    assign fwd_data_s2_32 = fwd_data[1];

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a queue-based reference model predicts
// readiness, occupancy, forwarding and the ordered stream of register writes.
module tb_writeback_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [1:0]  ld_byte_off;
    logic        w_en;
    logic [4:0]  w_address_d_5;
    logic [31:0] w_data_dval_32;
    logic [4:0]  fwd_address_s1_5, fwd_address_s2_5;
    logic        fwd_hit_s1, fwd_hit_s2;
    logic [31:0] fwd_data_s1_32, fwd_data_s2_32;
    logic [$clog2(DEPTH):0] occupancy;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_addr         (alu_addr),
        .alu_data         (alu_data),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_addr          (ld_addr),
        .ld_data          (ld_data),
        .ld_size          (ld_size),
        .ld_signed        (ld_signed),
        .ld_byte_off      (ld_byte_off),
        .w_en             (w_en),
        .w_address_d_5    (w_address_d_5),
        .w_data_dval_32   (w_data_dval_32),
        .fwd_address_s1_5 (fwd_address_s1_5),
        .fwd_address_s2_5 (fwd_address_s2_5),
        .fwd_hit_s1       (fwd_hit_s1),
        .fwd_hit_s2       (fwd_hit_s2),
        .fwd_data_s1_32   (fwd_data_s1_32),
        .fwd_data_s2_32   (fwd_data_s2_32),
        .occupancy        (occupancy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         pend[$];
    wr_t         exp_q[$];
    logic        m_wen   = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_extend(input logic [31:0] raw, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] off);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (raw >> (8 * int'(off))) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (raw >> (16 * (int'(off) / 2))) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    function automatic logic [32:0] model_fwd(input logic [4:0] a);
        logic [32:0] r;
        r = '0;
        if (a != 5'd0) begin
            if (m_wen && m_waddr == a) r = {1'b1, m_wdata};
            foreach (pend[i]) if (pend[i].addr == a) r = {1'b1, pend[i].data};
        end
        return r;
    endfunction

    // Drives one cycle of inputs, checks combinational outputs, then advances
    // the reference model across the rising edge and checks registered state.
    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] la, input logic [31:0] lraw,
                                 input logic [1:0] ls, input logic lsg, input logic [1:0] lo,
                                 input logic [4:0] f1, input logic [4:0] f2);
        int          free_n;
        logic        e_ldr, e_alur;
        logic [32:0] e_f1, e_f2;
        @(negedge clock);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid = lv; ld_addr = la; ld_data = lraw;
        ld_size = ls; ld_signed = lsg; ld_byte_off = lo;
        fwd_address_s1_5 = f1; fwd_address_s2_5 = f2;
        #1;
        free_n = DEPTH - pend.size();
        e_ldr  = (free_n >= 1);
        e_alur = (free_n >= 2) || ((free_n >= 1) && !lv);
        e_f1   = model_fwd(f1);
        e_f2   = model_fwd(f2);
        checkOutput("ld_ready", 32'(ld_ready), 32'(e_ldr));
        checkOutput("alu_ready", 32'(alu_ready), 32'(e_alur));
        checkOutput("fwd_hit_s1", 32'(fwd_hit_s1), 32'(e_f1[32]));
        checkOutput("fwd_data_s1", fwd_data_s1_32, e_f1[31:0]);
        checkOutput("fwd_hit_s2", 32'(fwd_hit_s2), 32'(e_f2[32]));
        checkOutput("fwd_data_s2", fwd_data_s2_32, e_f2[31:0]);
        @(posedge clock);
        if (pend.size() > 0) begin
            wr_t h;
            h = pend.pop_front();
            m_wen = 1'b1; m_waddr = h.addr; m_wdata = h.data;
        end else begin
            m_wen = 1'b0;
        end
        if (lv && e_ldr && la != 5'd0) begin
            wr_t e;
            e.addr = la; e.data = model_extend(lraw, ls, lsg, lo);
            pend.push_back(e); exp_q.push_back(e);
        end
        if (av && e_alur && aa != 5'd0) begin
            wr_t e;
            e.addr = aa; e.data = ad;
            pend.push_back(e); exp_q.push_back(e);
        end
        #1;
        checkOutput("w_en", 32'(w_en), 32'(m_wen));
        checkOutput("occupancy", 32'(occupancy), 32'(pend.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'b10, 1'b0, 2'd0, 5'd0, 5'd0);
    endtask

    // Asserts reset between edges and checks that it takes effect at once.
    task automatic applyReset(input logic [4:0] f1, input logic [4:0] f2);
        @(negedge clock);
        alu_valid = 1'b0; ld_valid = 1'b0;
        fwd_address_s1_5 = f1; fwd_address_s2_5 = f2;
        #2;
        reset = 1'b1;
        #1;
        pend.delete(); exp_q.delete();
        m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        checkOutput("rst_w_en", 32'(w_en), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_w_addr", 32'(w_address_d_5), 32'd0);
        checkOutput("rst_w_data", w_data_dval_32, 32'd0);
        checkOutput("rst_fwd_hit_s1", 32'(fwd_hit_s1), 32'd0);
        checkOutput("rst_fwd_hit_s2", 32'(fwd_hit_s2), 32'd0);
        checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("rst_alu_ready", 32'(alu_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every write presented on the register-file port
    // must be the oldest outstanding expected write.
    always @(negedge clock) begin
        if (w_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL spurious_write: got w_en=1 addr %0d data 0x%08h, expected no write at %0t",
                         w_address_d_5, w_data_dval_32, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("w_addr", 32'(w_address_d_5), 32'(e.addr));
                checkOutput("w_data", w_data_dval_32, e.data);
            end
        end
    end

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        ld_size = 2'b10; ld_signed = 1'b0; ld_byte_off = '0;
        fwd_address_s1_5 = '0; fwd_address_s2_5 = '0;
        #1;
        checkOutput("init_w_en", 32'(w_en), 32'd0);
        checkOutput("init_occupancy", 32'(occupancy), 32'd0);
        checkOutput("init_w_addr", 32'(w_address_d_5), 32'd0);
        checkOutput("init_w_data", w_data_dval_32, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] single ALU write");
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 2'b10, 1'b0, 2'd0, 5'd5, 5'd0);
        idle(3);

        $display("[TB] load extension");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h8081_F0FF, 2'b00, 1'b1, 2'd1, 5'd1, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h8081_F0FF, 2'b01, 1'b0, 2'd2, 5'd1, 5'd2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h8081_F0FF, 2'b10, 1'b0, 2'd0, 5'd2, 5'd3);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h8081_F0FF, 2'b11, 1'b1, 2'd3, 5'd4, 5'd3);
        idle(3);

        $display("[TB] simultaneous arrival with one free slot");
        applyStimulus(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 2'b10, 1'b0, 2'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14, 2'b10, 1'b0, 2'd0, 5'd11, 5'd12);
        applyStimulus(1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 32'h16, 2'b10, 1'b0, 2'd0, 5'd13, 5'd14);
        applyStimulus(1'b1, 5'd15, 32'h15, 1'b0, 5'd0, 32'd0, 2'b10, 1'b0, 2'd0, 5'd15, 5'd16);
        idle(5);

        $display("[TB] forwarding");
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 2'b10, 1'b0, 2'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 32'hA, 2'b10, 1'b0, 2'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'b10, 1'b0, 2'd0, 5'd7, 5'd3);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'b10, 1'b0, 2'd0, 5'd0, 5'd9);
        idle(3);

        $display("[TB] full and wrap");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, (i % 4 == 2) ? 5'd0 : 5'(i + 1), 32'(32'hA000 + i),
                          1'b1, (i % 5 == 3) ? 5'd0 : 5'(i + 20), 32'(32'hB000 + i),
                          2'b10, 1'b0, 2'd0, 5'(i + 1), 5'(i + 20));
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, (i % 3 == 0) ? 5'd0 : 5'(i + 1), 32'(32'hC000 + i),
                          1'b0, 5'd0, 32'd0, 2'b10, 1'b0, 2'd0, 5'(i), 5'(i + 1));
        idle(6);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, 2'b10, 1'b0, 2'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103, 2'b10, 1'b0, 2'd0, 5'd0, 5'd0);
        checkOutput("pre_reset_occupancy", 32'(occupancy), 32'd3);
        applyReset(5'd12, 5'd11);
        idle(6);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (i == 200) applyReset(5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)));
        end
        idle(DEPTH + 3);
        checkOutput("drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
